// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings for the IF/MEM data-RAM port arbiter:
//               FSM state encoding, requester port ids, and the RW / size
//               encodings used by the ram256x8 control pins.
// Config      : none (ALIGN_CHECK_EN is consumed by mem_port_arbiter)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_t;

    localparam logic c_PORT_IF   = 1'b0;
    localparam logic c_PORT_MEM  = 1'b1;

    localparam logic c_RW_READ   = 1'b0;
    localparam logic c_RW_WRITE  = 1'b1;

    localparam logic c_SIZE_BYTE = 1'b0;
    localparam logic c_SIZE_WORD = 1'b1;

    // A word access must sit on a 4-byte boundary; byte accesses never fault.
    function automatic logic is_misaligned(input logic size, input logic [7:0] addr);
        return (size == c_SIZE_WORD) && (addr[1:0] != 2'b00);
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_priority.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_priority
// Description : Grant pick for the data-RAM arbiter. MEM has fixed priority
//               over IF; a saturating 4-bit starvation counter forces IF to
//               win once it has lost STARVE_MAX simultaneous arbitrations.
// Ports       : clk      - clock, rising edge
//               R        - asynchronous active-high reset
//               if_req   - IF request
//               mem_req  - MEM request
//               arb      - arbitration strobe (one per granted transfer)
//               grant    - granted port id (c_PORT_IF / c_PORT_MEM)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic R,
    input  logic if_req,
    input  logic mem_req,
    input  logic arb,
    output logic grant
);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;
    logic       w_both;

    assign w_both = if_req & mem_req;

    always_comb begin
        grant = c_PORT_MEM;
        if (if_req && !mem_req) begin
            grant = c_PORT_IF;
        end else if (w_both && (starve_cnt_q == 4'(STARVE_MAX))) begin
            grant = c_PORT_IF;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (arb) begin
            if (if_req && (grant == c_PORT_IF)) begin
                starve_cnt_d = 4'd0;
            end else if (w_both && (starve_cnt_q != 4'hF)) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule : mem_arb_priority
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single-ported 256x8 data RAM between the IF fetch
//               port and the MEM data port. IDLE arbitrates and latches the
//               request, ACCESS drives the RAM for LAT cycles and captures
//               read data on the last one, ACK pulses the granted port's ack.
// Config      : ALIGN_CHECK_EN - when defined, misaligned word accesses skip
//               the RAM and are acked in the next cycle with rdata=0 (and
//               mem_err on the MEM port). Undefined: mem_err tied to 0.
// Ports       : clk, R (async active-high reset)
//               if_req/if_addr -> if_ack/if_rdata         (fetch port)
//               mem_req/mem_rw/mem_size/mem_addr/mem_wdata
//                 -> mem_ack/mem_rdata/mem_err            (data port)
//               stall_if, stall_mem                       (pipeline stalls)
//               ram_E/ram_RW/ram_Size/ram_A/ram_DI, ram_DO (RAM side)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        R,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_rw,
    input  logic        mem_size,
    input  logic [7:0]  mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        ram_E,
    output logic        ram_RW,
    output logic        ram_Size,
    output logic [7:0]  ram_A,
    output logic [31:0] ram_DI,
    input  logic [31:0] ram_DO
);

    state_t      state_q,     state_d;
    logic [3:0]  lat_cnt_q,   lat_cnt_d;
    logic        port_q,      port_d;
    logic [7:0]  addr_q,      addr_d;
    logic        rw_q,        rw_d;
    logic        size_q,      size_d;
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        w_arb;
    logic        w_grant;
    logic [7:0]  w_req_addr;
    logic        w_req_rw;
    logic        w_req_size;
    logic        w_misalign;
    logic        w_access;

    // One arbitration per transfer: only in IDLE and only with a live request.
    assign w_arb = (state_q == IDLE) && (if_req || mem_req);

    mem_arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_priority (
        .clk     (clk),
        .R       (R),
        .if_req  (if_req),
        .mem_req (mem_req),
        .arb     (w_arb),
        .grant   (w_grant)
    );

    // IF is always a word read regardless of what the MEM pins carry.
    assign w_req_addr = (w_grant == c_PORT_IF) ? if_addr     : mem_addr;
    assign w_req_rw   = (w_grant == c_PORT_IF) ? c_RW_READ   : mem_rw;
    assign w_req_size = (w_grant == c_PORT_IF) ? c_SIZE_WORD : mem_size;

`ifdef ALIGN_CHECK_EN
    logic err_q, err_d;
    assign w_misalign = is_misaligned(w_req_size, w_req_addr);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        port_d      = port_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef ALIGN_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (w_arb) begin
                    port_d    = w_grant;
                    addr_d    = w_req_addr;
                    rw_d      = w_req_rw;
                    size_d    = w_req_size;
                    wdata_d   = mem_wdata;
                    lat_cnt_d = 4'(LAT - 1);
`ifdef ALIGN_CHECK_EN
                    err_d     = w_misalign && (w_grant == c_PORT_MEM);
`endif
                    if (w_misalign) begin
                        // Faulting access never touches the RAM.
                        state_d = ACK;
                        if (w_grant == c_PORT_IF) begin
                            if_rdata_d = 32'd0;
                        end else begin
                            mem_rdata_d = 32'd0;
                        end
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_q == 4'd0) begin
                    lat_cnt_d = 4'd0;
                    state_d   = ACK;
                    if (rw_q == c_RW_READ) begin
                        if (port_q == c_PORT_IF) begin
                            if_rdata_d = ram_DO;
                        end else begin
                            mem_rdata_d = ram_DO;
                        end
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 4'd0;
            port_q      <= c_PORT_IF;
            addr_q      <= 8'd0;
            rw_q        <= 1'b0;
            size_q      <= 1'b0;
            wdata_q     <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
`ifdef ALIGN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
`ifdef ALIGN_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    assign w_access  = (state_q == ACCESS);

    assign ram_E     = w_access;
    assign ram_RW    = w_access & rw_q;
    assign ram_Size  = w_access & size_q;
    assign ram_A     = addr_q;
    assign ram_DI    = wdata_q;

    assign if_ack    = (state_q == ACK) && (port_q == c_PORT_IF);
    assign mem_ack   = (state_q == ACK) && (port_q == c_PORT_MEM);
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

`ifdef ALIGN_CHECK_EN
    assign mem_err   = mem_ack & err_q;
`else
    assign mem_err   = 1'b0;
`endif

    assign stall_if  = if_req  & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

endmodule : mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single-ported 256x8 data RAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage). It grants one requester at a time, sequences a fixed-latency RAM access, returns read data with a one-cycle acknowledge, and drives per-port stall signals back into the pipeline (PC/IF_ID load enable, MEM-side freeze). MEM has fixed priority over IF, and a starvation counter bounds how long IF can be held off.

## Interface
- LAT, 2, RAM access cycles per transfer; legal range 1..15.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win; legal range 1..15.
- clk  in  1  pipeline clock, rising edge.
- R  in  1  reset; asynchronous, active-high.
- if_req  in  1  IF fetch request; held until if_ack.
- if_addr  in  8  fetch byte address; always a word, read access.
- if_ack  out  1  one-cycle pulse; if_rdata is valid this cycle.
- if_rdata  out  32  fetched word; held until the next if_ack.
- mem_req  in  1  MEM request; held until mem_ack.
- mem_rw  in  1  1=write, 0=read.
- mem_size  in  1  1=word, 0=byte.
- mem_addr  in  8  data byte address.
- mem_wdata  in  32  write data (byte writes use [7:0]).
- mem_ack  out  1  one-cycle pulse.
- mem_rdata  out  32  read data; held until the next mem_ack.
- mem_err  out  1  pulse with mem_ack on a misaligned access (see Configuration); otherwise 0.
- stall_if  out  1  if_req & ~if_ack.
- stall_mem  out  1  mem_req & ~mem_ack.
- ram_E, ram_RW, ram_Size  out  1 each  RAM enable, RAM write, and RAM word-size controls.
- ram_A  out  8  RAM address.
- ram_DI  out  32  RAM write data.
- ram_DO  in  32  RAM read data.

## Operation
- FSM states:
  - IDLE: arbitration.
  - ACCESS: RAM active for LAT cycles.
  - ACK: response cycle.
- IDLE:
  - If only one req is high, grant that port.
  - If both are high, grant MEM, unless starve_cnt == STARVE_MAX, in which case grant IF.
  - On grant, latch port id, addr, rw, size and wdata, and load lat_cnt = LAT-1. Go to ACCESS.
- ACCESS:
  - ram_E=1. ram_A, ram_RW and ram_Size come from the latched values; IF forces read/word. ram_DI is the latched wdata.
  - lat_cnt decrements each cycle. On the cycle where lat_cnt==0, capture ram_DO into the granted port's rdata (reads only). Go to ACK.
- ACK: pulse the granted port's ack, then go to IDLE. No arbitration in ACK.
- starve_cnt (4-bit):
  - increments, saturating, when IF loses a simultaneous arbitration;
  - clears when IF is granted.
- A req dropped mid-transfer does not abort the transfer: the access completes and the ack still pulses. The requester ignores it.
- ram_E, ram_RW and ram_Size are 0 outside ACCESS. ram_A and ram_DI hold their last latched values.

## Timing
- Reset (asynchronous):
  - state=IDLE; starve_cnt, lat_cnt, latched regs, if_rdata and mem_rdata all 0;
  - every registered output 0;
  - stall outputs follow their formulas.
- Cycle numbering: req seen in IDLE at cycle 0.
  - ACCESS occupies cycles 1..LAT.
  - ack is high in cycle LAT+1.
  - IDLE at LAT+2.
- Throughput: one transfer per LAT+2 cycles.
- Reset asserted mid-ACCESS abandons the transfer with no ack. A partially completed write is not guaranteed.
- Simultaneous requests: the loser's stall stays high until its own ack.

## Configuration
- ALIGN_CHECK_EN defined:
  - A MEM word access with mem_addr[1:0]!=0 skips ACCESS: IDLE goes straight to ACK, ram_E stays 0.
  - mem_ack and mem_err pulse in cycle 1, and mem_rdata is set to 0.
  - IF is checked the same way, with no err port: if_rdata=0.
- ALIGN_CHECK_EN undefined:
  - Addresses pass through unchanged and every access uses the RAM.
  - mem_err is tied to 0.

## Structure
- Shared package holds:
  - state encoding: IDLE=2'b00, ACCESS=2'b01, ACK=2'b10;
  - port ids: PORT_IF=0, PORT_MEM=1;
  - RW and size encodings matching ram256x8.
- One sub-module, mem_arb_priority, holds the starvation counter and grant pick. Its inputs are the two reqs and an arbitrate strobe; its output is the grant id.

## Test plan
- Reset: R=1 with random inputs -> all acks, rdata and ram_E are 0, state IDLE. Release -> no activity until a req.
- Lone IF read at 0x04, RAM word 0xE3A01005, LAT=2 -> ram_E high in cycles 1-2; if_ack in cycle 3 with if_rdata=0xE3A01005; stall_if high in cycles 0-2.
- Simultaneous if_req (0x08) and MEM byte write of 0x5A to 0x20:
  - MEM is granted first, mem_ack in cycle 3, RAM[0x20]=0x5A;
  - IF is granted in cycle 4, if_ack in cycle 7.
- Starvation with STARVE_MAX=4 and both reqs held continuously -> four MEM grants, then the fifth arbitration grants IF and starve_cnt clears.
- R pulsed in cycle 1 of a MEM read -> outputs 0 immediately, no mem_ack. After release, the held req is re-arbitrated and acked LAT+1 cycles later.
- Misaligned MEM word read at 0x22:
  - with ALIGN_CHECK_EN: mem_ack and mem_err in cycle 1, ram_E never high, mem_rdata=0;
  - without it: ram_A=0x22 and a normal LAT access.
